// File: rtl/pkt_len_hdr_pkg.sv
// Shared types and constants for the length-header insertion stage.
package pkt_len_hdr_pkg;

  // Width of one data beat on the RX and TX streams.
  localparam int DATA_W = 512;

  // Position of the byte length inside the header beat.
  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_W   = 16;

  // Output sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } state_e;

  // One buffered data beat: the TLAST marker travels with its data.
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  // Build a header beat: the length sits in its field and every other bit is zero.
  function automatic logic [DATA_W-1:0] mk_hdr(input logic [HDR_LEN_W-1:0] len);
    logic [DATA_W-1:0] h;
    h = '0;
    h[HDR_LEN_LSB +: HDR_LEN_W] = len;
    return h;
  endfunction

endpackage

// File: rtl/pkt_len_hdr_if.sv
// Bundle of the three streams around pkt_len_hdr: packet data in,
// measured length in, header-prefixed packet out.
interface pkt_len_hdr_if;
  import pkt_len_hdr_pkg::*;

  // Packet data from the measurement stage.
  logic [DATA_W-1:0]    rx_tdata;
  logic                 rx_tvalid;
  logic                 rx_tlast;
  logic                 rx_tready;

  // Measured packet length in bytes, offered alongside the RX last beat.
  logic [HDR_LEN_W-1:0] len_tdata;
  logic                 len_tvalid;
  logic                 len_tready;

  // Header beat followed by the unchanged packet body.
  logic [DATA_W-1:0]    tx_tdata;
  logic                 tx_tvalid;
  logic                 tx_tlast;
  logic                 tx_tready;

  // View from pkt_len_hdr itself.
  modport slave (
    input  rx_tdata, rx_tvalid, rx_tlast,
    output rx_tready,
    input  len_tdata, len_tvalid,
    output len_tready,
    output tx_tdata, tx_tvalid, tx_tlast,
    input  tx_tready
  );

  // View from the surrounding pipeline (upstream source and downstream sink).
  modport master (
    output rx_tdata, rx_tvalid, rx_tlast,
    input  rx_tready,
    output len_tdata, len_tvalid,
    input  len_tready,
    input  tx_tdata, tx_tvalid, tx_tlast,
    output tx_tready
  );

endinterface

// File: rtl/pkt_len_hdr_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty flags.
// The head entry is always visible on dout_o; pop_i consumes it.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             wr_en_s, rd_en_s;

  assign wr_en_s = push_i & ~full_q;
  assign rd_en_s = pop_i & ~empty_q;

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

  // Next pointer, occupancy and flag values; a push and pop together leave occupancy unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    if (wr_en_s) begin
      if (wr_ptr_q == LAST_PTR) begin
        wr_ptr_d = '0;
      end else begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_en_s) begin
      if (rd_ptr_q == LAST_PTR) begin
        rd_ptr_d = '0;
      end else begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_en_s, rd_en_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    full_d  = (cnt_d == FULL_CNT);
    empty_d = (cnt_d == CW'(0));
  end

  // Storage array; contents are don't-care after reset because the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer, occupancy and flag registers; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

endmodule

// File: rtl/pkt_len_hdr.sv
// Store-and-forward length header insertion.
// Buffers each packet's beats and its measured byte length, then sends one
// header beat holding the length followed by the untouched packet body.
// A length only enters its FIFO together with the packet's last beat, so by
// the time a header is sent the complete body is already buffered.
module pkt_len_hdr
  import pkt_len_hdr_pkg::*;
#(
  parameter int DATA_DEPTH = 256,
  parameter int LEN_DEPTH  = 16
) (
  input  logic                clk,
  input  logic                reset,
  pkt_len_hdr_if.slave        axis,
  output logic                err_len_ovf
);

  // Sequencer encodings, kept numerically identical to the package enum.
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_HDR  = HDR;
  localparam logic [1:0] S_BODY = BODY;

  logic [1:0]           state_q, state_d;
  logic [DATA_W-1:0]    hdr_q, hdr_d;
  logic                 rdy_en_q;
  logic                 err_q;

  beat_t                d_din_s, d_dout_s;
  logic                 d_push_s, d_pop_s, d_full_s, d_empty_s;
  logic [HDR_LEN_W-1:0] l_dout_s;
  logic                 l_push_s, l_pop_s, l_full_s, l_empty_s;

  logic                 rx_tready_s, len_tready_s;
  logic                 tx_valid_s, tx_last_s;
  logic [DATA_W-1:0]    tx_data_s;

  // RX also waits on the length FIFO: the upstream length is not gated by
  // TREADY, so a last beat must never be taken when its length has no room.
  assign rx_tready_s  = rdy_en_q & ~d_full_s & ~l_full_s;
  assign len_tready_s = rdy_en_q & ~l_full_s;

  assign d_din_s.last = axis.rx_tlast;
  assign d_din_s.data = axis.rx_tdata;
  assign d_push_s     = axis.rx_tvalid & rx_tready_s;
  assign l_push_s     = axis.len_tvalid & len_tready_s;

  sync_fifo #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (DATA_DEPTH)
  ) u_data_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (d_push_s),
    .din_i   (d_din_s),
    .pop_i   (d_pop_s),
    .dout_o  (d_dout_s),
    .full_o  (d_full_s),
    .empty_o (d_empty_s)
  );

  sync_fifo #(
    .WIDTH (HDR_LEN_W),
    .DEPTH (LEN_DEPTH)
  ) u_len_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (l_push_s),
    .din_i   (axis.len_tdata),
    .pop_i   (l_pop_s),
    .dout_o  (l_dout_s),
    .full_o  (l_full_s),
    .empty_o (l_empty_s)
  );

  // Sequencer: wait for a length, present its header, then stream the body up to TLAST.
  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    l_pop_s    = 1'b0;
    d_pop_s    = 1'b0;
    tx_valid_s = 1'b0;
    tx_last_s  = 1'b0;
    tx_data_s  = '0;

    case (state_q)
      S_IDLE: begin
        if (!l_empty_s) begin
          hdr_d   = mk_hdr(l_dout_s);
          state_d = S_HDR;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_HDR: begin
        tx_valid_s = 1'b1;
        tx_data_s  = hdr_q;
        if (axis.tx_tready) begin
          l_pop_s = 1'b1;
          state_d = S_BODY;
        end else begin
          state_d = S_HDR;
        end
      end

      S_BODY: begin
        // The body is complete on entry; following empty only guards against misuse.
        tx_valid_s = ~d_empty_s;
        tx_data_s  = d_dout_s.data;
        tx_last_s  = d_dout_s.last;
        if (tx_valid_s && axis.tx_tready) begin
          d_pop_s = 1'b1;
          if (d_dout_s.last) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_BODY;
          end
        end else begin
          state_d = S_BODY;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, header, ready-enable and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      hdr_q    <= '0;
      rdy_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      rdy_en_q <= 1'b1;
      err_q    <= err_q | (axis.len_tvalid & ~len_tready_s);
    end
  end

  assign axis.rx_tready  = rx_tready_s;
  assign axis.len_tready = len_tready_s;
  assign axis.tx_tvalid  = tx_valid_s;
  assign axis.tx_tdata   = tx_data_s;
  assign axis.tx_tlast   = tx_last_s;
  assign err_len_ovf     = err_q;

endmodule

// File: tb/tb_pkt_len_hdr.sv
// Directed bench for pkt_len_hdr: vector table of single packets plus
// hand-written sequences for back-to-back, backpressure, length FIFO full
// and reset in the middle of a body.
module tb_pkt_len_hdr;
  import pkt_len_hdr_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic err_len_ovf;

  always #5 clk = ~clk;

  pkt_len_hdr_if axis();

  pkt_len_hdr #(.DATA_DEPTH(256), .LEN_DEPTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .axis        (axis),
    .err_len_ovf (err_len_ovf)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic         last;
    logic [511:0] data;
  } obs_t;

  typedef struct {
    logic         last;
    logic [511:0] data;
  } exp_t;

  obs_t log_q[$];
  exp_t exp_q[$];
  int   rd_idx = 0;

  int           stab_chk = 0;
  int           stab_err = 0;
  logic         pend = 1'b0;
  logic [511:0] pd = '0;
  logic         pl = 1'b0;

  // TX monitor: log every accepted beat and watch stalled beats for changes.
  always @(negedge clk) begin
    if (!reset && axis.tx_tvalid && axis.tx_tready) begin
      log_q.push_back('{cyc, axis.tx_tlast, axis.tx_tdata});
    end
    if (pend && !reset) begin
      stab_chk <= stab_chk + 1;
      if (!axis.tx_tvalid || axis.tx_tdata !== pd || axis.tx_tlast !== pl)
        stab_err <= stab_err + 1;
    end
    pend <= !reset && axis.tx_tvalid && !axis.tx_tready;
    pd   <= axis.tx_tdata;
    pl   <= axis.tx_tlast;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic chk_wide(input string name, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  bit bp_en = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    if (bp_en) axis.tx_tready = ($urandom_range(0, 9) < 3);
  endtask

  function automatic logic [511:0] beat(input int n);
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = 32'(n * 16 + i) ^ 32'hC3A5_0000;
    return v;
  endfunction

  function automatic logic [511:0] hdr_of(input logic [15:0] len);
    logic [511:0] h;
    h = '0;
    h[15:0] = len;
    return h;
  endfunction

  int nxt_base = 0;
  int last_hs_cyc = 0;

  // Offer one packet; its length goes out alongside the accepted last beat.
  task automatic send_pkt(input logic [15:0] len, input int nb);
    int k = 0;
    int guard = 0;
    while (k < nb && guard < 500) begin
      axis.rx_tdata   = beat(nxt_base + k);
      axis.rx_tvalid  = 1'b1;
      axis.rx_tlast   = (k == nb - 1);
      axis.len_tdata  = len;
      axis.len_tvalid = (k == nb - 1) && axis.rx_tready;
      if (axis.rx_tready) begin
        if (k == nb - 1) last_hs_cyc = cyc;
        k++;
      end
      step();
      guard++;
    end
    axis.rx_tvalid  = 1'b0;
    axis.rx_tlast   = 1'b0;
    axis.len_tvalid = 1'b0;
    chk("send_done", k, nb);
    exp_q.push_back('{1'b0, hdr_of(len)});
    for (int j = 0; j < nb; j++) exp_q.push_back('{(j == nb - 1), beat(nxt_base + j)});
    nxt_base += nb;
  endtask

  // Wait for the expected beats to appear on TX and compare them in order.
  task automatic check_out(input string name);
    int guard = 0;
    int n;
    n = exp_q.size();
    while (log_q.size() < rd_idx + n && guard < 2000) begin
      step();
      guard++;
    end
    chk({name, "_count"}, log_q.size() - rd_idx, n);
    for (int i = 0; i < n; i++) begin
      if (rd_idx < log_q.size()) begin
        chk_wide({name, "_data"}, log_q[rd_idx].data, exp_q[i].data);
        chk({name, "_last"}, log_q[rd_idx].last, exp_q[i].last);
        rd_idx++;
      end
    end
    exp_q.delete();
  endtask

  typedef struct {
    logic [15:0] len;
    int          nb;
    logic [15:0] exp_hdr;
    int          exp_lat;
    int          exp_beats;
  } vec_t;

  vec_t vt[6];

  initial begin
    int hidx;
    int b0;
    int g;

    vt[0] = '{16'd150,   3, 16'd150,   2, 4};
    vt[1] = '{16'd0,     1, 16'd0,     2, 2};
    vt[2] = '{16'd64,    1, 16'd64,    2, 2};
    vt[3] = '{16'd1,     1, 16'd1,     2, 2};
    vt[4] = '{16'd128,   2, 16'd128,   2, 3};
    vt[5] = '{16'hFFFF,  2, 16'hFFFF,  2, 3};

    axis.rx_tdata   = '0;
    axis.rx_tvalid  = 1'b0;
    axis.rx_tlast   = 1'b0;
    axis.len_tdata  = '0;
    axis.len_tvalid = 1'b0;
    axis.tx_tready  = 1'b0;

    // Reset values.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", axis.tx_tvalid, 0);
    chk("rst_tlast", axis.tx_tlast, 0);
    chk_wide("rst_tdata", axis.tx_tdata, '0);
    chk("rst_rx_rdy", axis.rx_tready, 0);
    chk("rst_len_rdy", axis.len_tready, 0);
    chk("rst_err", err_len_ovf, 0);
    reset = 1'b0;
    chk("rdy_low_at_release", axis.rx_tready, 0);
    step();
    chk("rdy_rise_rx", axis.rx_tready, 1);
    chk("rdy_rise_len", axis.len_tready, 1);
    axis.tx_tready = 1'b1;

    // Single packets from the vector table, including zero length and the maximum length value.
    for (int i = 0; i < 6; i++) begin
      hidx = rd_idx;
      send_pkt(vt[i].len, vt[i].nb);
      check_out("vec");
      chk("vec_beats", rd_idx - hidx, vt[i].exp_beats);
      if (hidx < log_q.size()) begin
        chk("vec_hdr_len", log_q[hidx].data[15:0], vt[i].exp_hdr);
        chk("vec_hdr_hi_zero", (log_q[hidx].data[511:16] == '0), 1);
        chk("vec_hdr_last", log_q[hidx].last, 0);
        chk("vec_latency", log_q[hidx].cyc - last_hs_cyc, vt[i].exp_lat);
      end
      repeat (3) step();
    end

    // Back-to-back packets: one idle cycle between groups.
    b0 = rd_idx;
    send_pkt(16'd64, 1);
    send_pkt(16'd1, 1);
    send_pkt(16'd128, 2);
    check_out("b2b");
    if (log_q.size() >= b0 + 7) begin
      chk("b2b_gap1", log_q[b0 + 2].cyc - log_q[b0 + 1].cyc, 2);
      chk("b2b_gap2", log_q[b0 + 4].cyc - log_q[b0 + 3].cyc, 2);
      chk("b2b_body_rate", log_q[b0 + 6].cyc - log_q[b0 + 5].cyc, 1);
    end
    repeat (3) step();

    // Random backpressure on TX.
    bp_en = 1'b1;
    send_pkt(16'd170, 3);
    send_pkt(16'd10, 1);
    send_pkt(16'd300, 5);
    send_pkt(16'd77, 2);
    check_out("bp");
    bp_en = 1'b0;
    axis.tx_tready = 1'b1;
    chk("bp_stable_err", stab_err, 0);
    chk("bp_stalls_seen", (stab_chk > 0), 1);
    repeat (3) step();

    // Length FIFO full with TX stalled.
    axis.tx_tready = 1'b0;
    for (int i = 0; i < 16; i++) send_pkt(16'(i + 1), 1);
    chk("lf_rx_rdy_low", axis.rx_tready, 0);
    chk("lf_len_rdy_low", axis.len_tready, 0);
    chk("lf_err_still0", err_len_ovf, 0);
    axis.len_tdata  = 16'd999;
    axis.len_tvalid = 1'b1;
    step();
    axis.len_tvalid = 1'b0;
    chk("ovf_set", err_len_ovf, 1);
    step();
    chk("ovf_sticky", err_len_ovf, 1);
    axis.tx_tready = 1'b1;
    step();
    chk("lf_rdy_back", axis.rx_tready, 1);
    check_out("lf");
    chk("lf_stable_err", stab_err, 0);
    repeat (3) step();

    // Reset after the header and one of four body beats.
    axis.tx_tready = 1'b0;
    send_pkt(16'd200, 4);
    g = 0;
    while (!axis.tx_tvalid && g < 50) begin
      step();
      g++;
    end
    chk("rb_hdr_valid", axis.tx_tvalid, 1);
    axis.tx_tready = 1'b1;
    step();
    step();
    axis.tx_tready = 1'b0;
    reset = 1'b1;
    step();
    chk("rb_tvalid_off", axis.tx_tvalid, 0);
    chk("rb_rx_rdy_rst", axis.rx_tready, 0);
    chk("rb_err_clr", err_len_ovf, 0);
    reset = 1'b0;
    axis.tx_tready = 1'b1;
    repeat (3) void'(exp_q.pop_back());
    repeat (4) step();
    chk("rb_idle", axis.tx_tvalid, 0);
    chk("rb_partial_beats", log_q.size() - rd_idx, 2);
    check_out("rb_pre");
    send_pkt(16'd100, 2);
    check_out("rb_post");

    repeat (5) step();
    chk("no_extra_beats", log_q.size(), rd_idx);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
